// File: rtl/dot_product_mem_pipeline.sv
// Dot-product engine: host loads vector words into mem1/mem2, an FSM streams every
// address pair through a 4-lane multiply-accumulate and a result FIFO into mem3.
module dot_product_mem_pipeline #(
  parameter int DATA_WIDTH           = 32,
  parameter int VECTOR_WIDTH         = 4,
  parameter int VECTOR_ELEMENT_WIDTH = 8,
  parameter int ADDR_WIDTH           = 5,
  parameter int MEM_SIZE             = 32,
  parameter int RESULT_WIDTH         = 16,
  parameter int FIFO_DEPTH           = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start_processing,
  input  logic                  mem1_write_en,
  input  logic [ADDR_WIDTH-1:0] mem1_write_address,
  input  logic [DATA_WIDTH-1:0] mem1_data_in,
  input  logic                  mem2_write_en,
  input  logic [ADDR_WIDTH-1:0] mem2_write_address,
  input  logic [DATA_WIDTH-1:0] mem2_data_in,
  input  logic                  mem3_read_en,
  input  logic [ADDR_WIDTH-1:0] mem3_read_address,
  output logic [DATA_WIDTH-1:0] mem3_data_out,
  output logic                  fsm_ready
);

  localparam int VEW     = VECTOR_ELEMENT_WIDTH;
  localparam int CNT_W   = ADDR_WIDTH + 1;
  localparam int FIFO_AW = $clog2(FIFO_DEPTH);
  localparam int OCC_W   = FIFO_AW + 2;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t                  state_r;
  logic                    fsm_ready_r;
  logic [DATA_WIDTH-1:0]   mem1_r [MEM_SIZE];
  logic [DATA_WIDTH-1:0]   mem2_r [MEM_SIZE];
  logic [DATA_WIDTH-1:0]   mem3_r [MEM_SIZE];
  logic [DATA_WIDTH-1:0]   mem3_data_out_r;
  logic [ADDR_WIDTH-1:0]   rd_addr_r;
  logic [ADDR_WIDTH-1:0]   wr_addr_r;
  logic [CNT_W-1:0]        wr_count_r;
  logic                    rd_valid_r;
  logic                    res_valid_r;
  logic [DATA_WIDTH-1:0]   rd_a_r;
  logic [DATA_WIDTH-1:0]   rd_b_r;
  logic [RESULT_WIDTH-1:0] result_r;
  logic [RESULT_WIDTH-1:0] fifo_r [FIFO_DEPTH];
  logic [FIFO_AW-1:0]      fifo_wp_r;
  logic [FIFO_AW-1:0]      fifo_rp_r;
  logic [FIFO_AW:0]        fifo_count_r;
  logic [OCC_W-1:0]        occupancy_s;
  logic                    issue_s;
  logic                    pop_s;
  logic                    pass_start_s;

  // Unsigned dot product of packed elements, element 0 in the most significant lane.
  function automatic logic [RESULT_WIDTH-1:0] dot_f(input logic [DATA_WIDTH-1:0] a,
                                                    input logic [DATA_WIDTH-1:0] b);
    logic [RESULT_WIDTH-1:0] acc;
    logic [2*VEW-1:0]        ea;
    logic [2*VEW-1:0]        eb;
    logic [2*VEW-1:0]        prod;
    acc = '0;
    for (int k = 0; k < VECTOR_WIDTH; k++) begin
      ea   = {{VEW{1'b0}}, a[(VECTOR_WIDTH-1-k)*VEW +: VEW]};
      eb   = {{VEW{1'b0}}, b[(VECTOR_WIDTH-1-k)*VEW +: VEW]};
      prod = ea * eb;
      acc  = acc + RESULT_WIDTH'(prod);
    end
    return acc;
  endfunction

  // Issue gating: results already queued plus reads in flight must leave FIFO room.
  always_comb begin
    occupancy_s  = OCC_W'(fifo_count_r) + OCC_W'(rd_valid_r) + OCC_W'(res_valid_r);
    pop_s        = (fifo_count_r != '0);
    pass_start_s = (state_r == IDLE) && start_processing;
    if ((state_r == READ) && (occupancy_s < OCC_W'(FIFO_DEPTH))) begin
      issue_s = 1'b1;
    end else begin
      issue_s = 1'b0;
    end
  end

  // Host-side loading of the two source memories, only while idle.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < MEM_SIZE; i++) begin
        mem1_r[i] <= '0;
        mem2_r[i] <= '0;
      end
    end else begin
      if (mem1_write_en && fsm_ready_r) mem1_r[mem1_write_address] <= mem1_data_in;
      if (mem2_write_en && fsm_ready_r) mem2_r[mem2_write_address] <= mem2_data_in;
    end
  end

  // Control FSM plus the read and multiply-accumulate pipeline stages.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r     <= IDLE;
      fsm_ready_r <= 1'b1;
      rd_addr_r   <= '0;
      rd_valid_r  <= 1'b0;
      res_valid_r <= 1'b0;
      rd_a_r      <= '0;
      rd_b_r      <= '0;
      result_r    <= '0;
    end else begin
      rd_valid_r  <= issue_s;
      res_valid_r <= rd_valid_r;
      if (issue_s) begin
        rd_a_r    <= mem1_r[rd_addr_r];
        rd_b_r    <= mem2_r[rd_addr_r];
        rd_addr_r <= rd_addr_r + ADDR_WIDTH'(1);
      end
      if (rd_valid_r) result_r <= dot_f(rd_a_r, rd_b_r);
      case (state_r)
        IDLE: begin
          if (start_processing) begin
            state_r     <= READ;
            fsm_ready_r <= 1'b0;
            rd_addr_r   <= '0;
          end
        end
        READ: begin
          if (issue_s && (rd_addr_r == ADDR_WIDTH'(MEM_SIZE - 1))) state_r <= DRAIN;
        end
        DRAIN: begin
          if (wr_count_r == CNT_W'(MEM_SIZE)) state_r <= DONE;
        end
        DONE: begin
          if (!start_processing) begin
            state_r     <= IDLE;
            fsm_ready_r <= 1'b1;
          end
        end
        default: begin
          state_r     <= IDLE;
          fsm_ready_r <= 1'b1;
        end
      endcase
    end
  end

  // Result FIFO, writer into mem3 (one slot ahead of the source address), host readback.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < MEM_SIZE; i++) mem3_r[i] <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) fifo_r[i] <= '0;
      fifo_wp_r       <= '0;
      fifo_rp_r       <= '0;
      fifo_count_r    <= '0;
      wr_addr_r       <= '0;
      wr_count_r      <= '0;
      mem3_data_out_r <= '0;
    end else begin
      if (mem3_read_en) mem3_data_out_r <= mem3_r[mem3_read_address];
      if (res_valid_r) begin
        fifo_r[fifo_wp_r] <= result_r;
        fifo_wp_r         <= fifo_wp_r + FIFO_AW'(1);
      end
      if (pop_s) begin
        mem3_r[wr_addr_r] <= DATA_WIDTH'(fifo_r[fifo_rp_r]);
        fifo_rp_r         <= fifo_rp_r + FIFO_AW'(1);
        wr_addr_r         <= wr_addr_r + ADDR_WIDTH'(1);
        wr_count_r        <= wr_count_r + CNT_W'(1);
      end
      fifo_count_r <= fifo_count_r + (FIFO_AW+1)'(res_valid_r) - (FIFO_AW+1)'(pop_s);
      if (pass_start_s) begin
        wr_addr_r  <= ADDR_WIDTH'(1);
        wr_count_r <= '0;
      end
    end
  end

  assign mem3_data_out = mem3_data_out_r;
  assign fsm_ready     = fsm_ready_r;

endmodule

// File: tb/tb_dot_product_mem_pipeline.sv
// Directed bench for dot_product_mem_pipeline: hand-computed dot products read back
// from mem3, plus busy-write rejection, held start and mid-pass reset.
module tb_dot_product_mem_pipeline;

  logic        clk;
  logic        rst_n;
  logic        start_processing;
  logic        mem1_write_en;
  logic [4:0]  mem1_write_address;
  logic [31:0] mem1_data_in;
  logic        mem2_write_en;
  logic [4:0]  mem2_write_address;
  logic [31:0] mem2_data_in;
  logic        mem3_read_en;
  logic [4:0]  mem3_read_address;
  logic [31:0] mem3_data_out;
  logic        fsm_ready;

  int total;
  int bad;
  logic [31:0] rd_val;

  dot_product_mem_pipeline dut (
    .clk                (clk),
    .rst_n              (rst_n),
    .start_processing   (start_processing),
    .mem1_write_en      (mem1_write_en),
    .mem1_write_address (mem1_write_address),
    .mem1_data_in       (mem1_data_in),
    .mem2_write_en      (mem2_write_en),
    .mem2_write_address (mem2_write_address),
    .mem2_data_in       (mem2_data_in),
    .mem3_read_en       (mem3_read_en),
    .mem3_read_address  (mem3_read_address),
    .mem3_data_out      (mem3_data_out),
    .fsm_ready          (fsm_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic wr_both(input logic [4:0] a, input logic [31:0] d1, input logic [31:0] d2);
    @(negedge clk);
    mem1_write_en      = 1'b1;
    mem1_write_address = a;
    mem1_data_in       = d1;
    mem2_write_en      = 1'b1;
    mem2_write_address = a;
    mem2_data_in       = d2;
    @(negedge clk);
    mem1_write_en = 1'b0;
    mem2_write_en = 1'b0;
  endtask

  task automatic rd3(input logic [4:0] a, output logic [31:0] v);
    @(negedge clk);
    mem3_read_en      = 1'b1;
    mem3_read_address = a;
    @(negedge clk);
    mem3_read_en = 1'b0;
    v = mem3_data_out;
  endtask

  // Runs one pass with start dropped after a single cycle; checks busy, completion and length.
  task automatic run_pass(input string tag);
    int cyc;
    @(negedge clk);
    start_processing = 1'b1;
    @(negedge clk);
    chk({tag, "_busy"}, 32'(fsm_ready), 32'd0);
    start_processing = 1'b0;
    cyc = 1;
    while (!fsm_ready && cyc < 80) begin
      @(negedge clk);
      cyc++;
    end
    chk({tag, "_ready_again"}, 32'(fsm_ready), 32'd1);
    chk({tag, "_len_le_40"}, 32'(cyc <= 40), 32'd1);
  endtask

  initial begin
    total = 0;
    bad   = 0;
    rst_n = 1'b0;
    start_processing   = 1'b0;
    mem1_write_en      = 1'b0;
    mem1_write_address = 5'd0;
    mem1_data_in       = 32'd0;
    mem2_write_en      = 1'b0;
    mem2_write_address = 5'd0;
    mem2_data_in       = 32'd0;
    mem3_read_en       = 1'b0;
    mem3_read_address  = 5'd0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("reset_ready", 32'(fsm_ready), 32'd1);
    chk("reset_dout", mem3_data_out, 32'd0);

    // 1*1+2*2+3*3+4*4 = 30 into mem3[1]
    wr_both(5'd0, 32'h01020304, 32'h01020304);
    run_pass("p1");
    rd3(5'd1, rd_val);
    chk("p1_mem3_1", rd_val, 32'd30);
    @(negedge clk);
    chk("p1_dout_hold", mem3_data_out, 32'd30);
    rd3(5'd2, rd_val);
    chk("p1_mem3_2", rd_val, 32'd0);

    // Address 31 wraps into mem3[0]; MSB lane only: 5*7 = 35
    wr_both(5'd31, 32'h00000002, 32'h00000003);
    wr_both(5'd0, 32'h05000000, 32'h07000000);
    run_pass("p2");
    rd3(5'd0, rd_val);
    chk("p2_mem3_0", rd_val, 32'd6);
    rd3(5'd1, rd_val);
    chk("p2_mem3_1", rd_val, 32'd35);

    // Hold start through completion; writes during busy must be dropped
    @(negedge clk);
    start_processing = 1'b1;
    @(negedge clk);
    chk("hold_busy", 32'(fsm_ready), 32'd0);
    wr_both(5'd0, 32'hFFFFFFFF, 32'hFFFFFFFF);
    repeat (50) @(negedge clk);
    chk("hold_done_50", 32'(fsm_ready), 32'd0);
    repeat (20) @(negedge clk);
    chk("hold_done_70", 32'(fsm_ready), 32'd0);
    start_processing = 1'b0;
    @(negedge clk);
    chk("hold_release", 32'(fsm_ready), 32'd1);
    run_pass("p3");
    rd3(5'd1, rd_val);
    chk("p3_old_data_mem3_1", rd_val, 32'd35);

    // All ones: 4*255*255 = 260100, mod 65536 = 63492
    for (int i = 0; i < 32; i++) wr_both(5'(i), 32'hFFFFFFFF, 32'hFFFFFFFF);
    run_pass("p4");
    rd3(5'd0, rd_val);
    chk("p4_mem3_0", rd_val, 32'd63492);
    rd3(5'd1, rd_val);
    chk("p4_mem3_1", rd_val, 32'd63492);
    rd3(5'd17, rd_val);
    chk("p4_mem3_17", rd_val, 32'd63492);
    rd3(5'd31, rd_val);
    chk("p4_mem3_31", rd_val, 32'd63492);

    // Reset in the middle of READ clears everything
    @(negedge clk);
    start_processing = 1'b1;
    repeat (6) @(negedge clk);
    chk("mid_busy", 32'(fsm_ready), 32'd0);
    start_processing = 1'b0;
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    chk("mid_ready", 32'(fsm_ready), 32'd1);
    chk("mid_dout", mem3_data_out, 32'd0);
    rd3(5'd0, rd_val);
    chk("mid_mem3_0", rd_val, 32'd0);
    rd3(5'd5, rd_val);
    chk("mid_mem3_5", rd_val, 32'd0);
    rd3(5'd31, rd_val);
    chk("mid_mem3_31", rd_val, 32'd0);
    run_pass("p5");
    rd3(5'd1, rd_val);
    chk("p5_cleared_src_mem3_1", rd_val, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
